// File: rtl/pc_gen_btb.sv
// pc_gen_btb: fetch PC generator with a direct-mapped BTB of 2-bit saturating counters.
// Priority: reset/debug reset, jump, hold, predicted target, sequential +4.
module pc_gen_btb #(
    parameter int              ADDR_W        = 32,
    parameter int              BTB_DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter int              HOLD_W        = 3,
    parameter int              HOLD_PC_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_reset_flag_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_taken_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [ADDR_W-1:0]    target_q [BTB_DEPTH];
    logic [1:0]           ctr_q    [BTB_DEPTH];

    logic [IDX_W-1:0] pc_idx, u_idx;
    logic [TAG_W-1:0] pc_tag, u_tag;
    logic             pc_hit, u_hit, upd_we;
    logic [1:0]       u_ctr, ctr_d;
    logic             unused;

    assign pc_idx = pc_q[IDX_W+1:2];
    assign pc_tag = pc_q[ADDR_W-1:IDX_W+2];
    assign u_idx  = upd_pc_i[IDX_W+1:2];
    assign u_tag  = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign unused = ^upd_pc_i[1:0];

    always_comb begin
        pc_hit        = valid_q[pc_idx] && tag_q[pc_idx] == pc_tag;
        pred_taken_o  = pc_hit && ctr_q[pc_idx][1];
        pred_target_o = pred_taken_o ? target_q[pc_idx] : '0;
        u_hit         = valid_q[u_idx] && tag_q[u_idx] == u_tag;
        u_ctr         = ctr_q[u_idx];
        // A taken miss allocates weakly taken; a not-taken miss is ignored.
        ctr_d         = !u_hit ? 2'd2 :
                        upd_taken_i ? (u_ctr == 2'd3 ? u_ctr : u_ctr + 2'd1) :
                        (u_ctr == 2'd0 ? u_ctr : u_ctr - 2'd1);
        upd_we        = upd_valid_i && (u_hit || upd_taken_i);
        pc_d          = jtag_reset_flag_i ? RESET_ADDR :
                        jump_flag_i ? jump_addr_i :
                        hold_flag_i >= HOLD_W'(HOLD_PC_LEVEL) ? pc_q :
                        pred_taken_o ? pred_target_o :
                        pc_q + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            valid_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (upd_we) valid_q[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && upd_we) begin
            tag_q[u_idx] <= u_tag;
            ctr_q[u_idx] <= ctr_d;
            if (upd_taken_i) target_q[u_idx] <= upd_target_i;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: doc/pc_gen_btb.md
# pc_gen_btb

Parametrised program-counter generator for the fetch stage, with a direct-mapped branch target buffer (BTB) that uses 2-bit saturating counters. It generalises the plain PC register: address width, reset address, hold encoding and BTB depth are parameters, and it makes its own taken/not-taken predictions from branch outcomes reported back by execute. It sits between the pipeline control (jump/hold) and the instruction fetch address bus.

## Interface
- ADDR_W, 32, PC and target width
- BTB_DEPTH, 8, BTB entries; power of two, >= 2; IDX_W = log2(BTB_DEPTH)
- RESET_ADDR, 32'h0, PC value after reset
- HOLD_W, 3, hold flag width
- HOLD_PC_LEVEL, 1, PC holds when hold_flag_i >= this value (unsigned)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- jtag_reset_flag_i  in  1  debug reset of PC only
- jump_flag_i  in  1  redirect from execute
- jump_addr_i  in  ADDR_W  redirect target
- hold_flag_i  in  HOLD_W  pipeline hold level
- upd_valid_i  in  1  resolved branch report valid
- upd_pc_i  in  ADDR_W  PC of the resolved branch
- upd_target_i  in  ADDR_W  resolved target
- upd_taken_i  in  1  resolved outcome
- pc_o  out  ADDR_W  current fetch PC (registered)
- pred_taken_o  out  1  prediction for pc_o (combinational from pc_o and BTB state)
- pred_target_o  out  ADDR_W  predicted target for pc_o; 0 when pred_taken_o = 0

## Operation
- Entry fields: valid, tag = addr[ADDR_W-1:IDX_W+2], target[ADDR_W], ctr[2]. Index = addr[IDX_W+1:2]; bits [1:0] are ignored.
- Lookup: hit = valid[idx(pc_o)] && tag matches. pred_taken_o = hit && ctr[1].
- Next-PC priority, evaluated at each rising edge:
  1. rst or jtag_reset_flag_i -> RESET_ADDR.
  2. jump_flag_i -> jump_addr_i.
  3. hold_flag_i >= HOLD_PC_LEVEL -> pc_o unchanged.
  4. pred_taken_o -> pred_target_o.
  5. otherwise pc_o + 4, computed modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0x0.
- Update, on the edge where upd_valid_i = 1, at idx(upd_pc_i):
  - Hit, taken: ctr saturating +1 (max 3); target <= upd_target_i.
  - Hit, not taken: ctr saturating -1 (min 0); target is unchanged.
  - Miss, taken: allocate the entry and overwrite any alias. valid = 1, tag is written, target = upd_target_i, ctr = 2 (weakly taken).
  - Miss, not taken: no change.
- Update is independent of hold, jump and jtag reset. An update still proceeds in a cycle where jump_flag_i = 1.
- rst clears all valid bits. ctr and target are don't-care after reset. jtag_reset_flag_i does not touch the BTB.
- An update arriving on the same edge as rst is discarded.

## Timing
- pc_o changes only at rising edges. Redirect latency is 1 cycle: the jump is applied at the edge where jump_flag_i is sampled.
- pred_taken_o and pred_target_o are valid in the same cycle as pc_o, with zero latency.
- An update written at edge N is visible to lookups from cycle N+1 onward. A lookup in the same cycle as the update sees the old contents.
- Reset values: pc_o = RESET_ADDR, pred_taken_o = 0, pred_target_o = 0. The last two follow from all entries being invalid.
- When hold and prediction are both active, hold wins. The prediction is re-evaluated on the held PC each cycle.
- When jump and prediction are both active, jump wins.

## Test plan
- Reset held 2 cycles, then released with no hold -> pc_o = RESET_ADDR, then +4 each cycle; pred_taken_o = 0 throughout.
- hold_flag_i = 1 for 3 cycles starting at pc_o = 0x10 -> pc_o stays 0x10; on release, next value is 0x14. Jump to 0x200 while hold = 1 -> pc_o = 0x200 on the next edge.
- Update {pc 0x20, target 0x80, taken} -> fetch reaching 0x20 shows pred_taken_o = 1, pred_target_o = 0x80; next pc_o = 0x80.
- Counter training: after allocation (ctr = 2), one not-taken update at 0x20 -> pred_taken_o = 0 at 0x20, next pc_o = 0x24. Four taken updates then saturate at 3; two not-taken updates are then needed to stop predicting.
- Alias with BTB_DEPTH = 8: allocate 0x20 -> 0x80, then a taken update for 0x40 (same index) -> 0x100. Result: 0x20 no longer predicts, 0x40 predicts 0x100. A not-taken update for an absent PC changes nothing.
- Wrap and debug reset: with ADDR_W = 32, pc_o = 0xFFFFFFFC -> next 0x0. Train entry at 0x20, then pulse jtag_reset_flag_i -> pc_o = RESET_ADDR and the 0x20 prediction survives. Pulse rst -> prediction gone, and an update sampled on the rst edge is not stored.
